// File: rtl/lsu_byte_seq_if.sv
// Core-side request/response channel of the byte-serial load/store sequencer.
// The core is the master; the sequencer is the slave.
interface lsu_byte_seq_if #(
    parameter int ADDR_W = 19
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_byte_seq.sv
// Turns one RV32I load/store into little-endian single-byte accesses on a
// byte-wide synchronous RAM port, returning an extended result or an error.
module lsu_byte_seq #(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    lsu_byte_seq_if.slave     bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    input  logic [7:0]        mem_rd
);
    typedef enum logic [1:0] {IDLE, ISSUE, LAST, RESP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, addr_hold_q;
    logic [31:0]       wdata_q, asm_q, asm_full, rdata_q;
    logic [2:0]        funct3_q;
    logic              we_q, err_q, req_bad;
    logic [1:0]        k_q, k_prev, last_k;

    function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic illegal, misaligned;
        illegal    = we ? (f3 > 3'b010)
                        : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000:  return {{24{a[7]}}, a[7:0]};
            3'b001:  return {{16{a[15]}}, a[15:0]};
            3'b100:  return {24'b0, a[7:0]};
            3'b101:  return {16'b0, a[15:0]};
            default: return a;
        endcase
    endfunction

    assign req_bad = bad_req(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
    assign k_prev  = k_q - 2'd1;

    // Index of the final byte: size 1, 2 or 4 from funct3[1:0].
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   last_k = 2'd0;
            2'b01:   last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
    end

    // Load result with the byte arriving in LAST merged in.
    always_comb begin
        asm_full                  = asm_q;
        asm_full[8*last_k +: 8]   = mem_rd;
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        mem_we         = 1'b0;
        mem_wd         = 8'h00;
        mem_addr       = addr_hold_q;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nxt = req_bad ? RESP : ISSUE;
            end
            ISSUE: begin
                mem_addr = base_q + ADDR_W'(k_q);
                mem_we   = we_q;
                if (we_q) mem_wd = wdata_q[8*k_q +: 8];
                if (k_q == last_k) state_nxt = we_q ? RESP : LAST;
            end
            LAST: state_nxt = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Holding the last presented address keeps the block-select mux (bits
    // [18:11]) steady in LAST, where the final read byte is still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            addr_hold_q <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            we_q        <= 1'b0;
            k_q         <= '0;
            asm_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            addr_hold_q <= mem_addr;
            case (state)
                IDLE: if (bus.req_valid) begin
                    base_q   <= bus.req_addr;
                    wdata_q  <= bus.req_wdata;
                    funct3_q <= bus.req_funct3;
                    we_q     <= bus.req_we;
                    k_q      <= '0;
                    err_q    <= req_bad;
                    rdata_q  <= '0;
                end
                ISSUE: begin
                    k_q <= k_q + 2'd1;
                    if (!we_q && k_q != 2'd0) asm_q[8*k_prev +: 8] <= mem_rd;
                end
                LAST: rdata_q <= extend(funct3_q, asm_full);
                RESP: if (bus.resp_ready) begin
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
